// File: rtl/aes_wrap_pkg.sv
// Shared register map, feeder FSM states and STATUS field positions for the
// queued AES-128 stream wrapper.
package aes_wrap_pkg;

    localparam logic [3:0] ADDR_STAGE0 = 4'd0;
    localparam logic [3:0] ADDR_STAGE1 = 4'd1;
    localparam logic [3:0] ADDR_STAGE2 = 4'd2;
    localparam logic [3:0] ADDR_STAGE3 = 4'd3;
    localparam logic [3:0] ADDR_PUSH   = 4'd4;
    localparam logic [3:0] ADDR_KEY    = 4'd5;
    localparam logic [3:0] ADDR_CT0    = 4'd6;
    localparam logic [3:0] ADDR_CT1    = 4'd7;
    localparam logic [3:0] ADDR_CT2    = 4'd8;
    localparam logic [3:0] ADDR_CT3    = 4'd9;
    localparam logic [3:0] ADDR_POP    = 4'd10;
    localparam logic [3:0] ADDR_STATUS = 4'd11;
    localparam logic [3:0] ADDR_IRQEN  = 4'd12;
    localparam logic [3:0] ADDR_CLR    = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        LOADKEY,
        FEED
    } feedState_e;

    localparam int ST_PT_LSB     = 24;
    localparam int ST_CT_LSB     = 16;
    localparam int ST_INF_LSB    = 8;
    localparam int ST_STICKY_LSB = 4;
    localparam int ST_KEYLD      = 2;
    localparam int ST_READY      = 1;
    localparam int ST_BUSY       = 0;

endpackage

// File: rtl/AES_Top.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded
// on the fly, Ready_new_input low while a block is being processed.
module AES_Top (
    input  logic         clk,
    input  logic         rst,
    input  logic         Load_Key,
    input  logic         Load_Data,
    input  logic [127:0] in_data,
    output logic         Ready_new_input,
    output logic         CTValid,
    output logic [127:0] CipherText
);

    localparam logic [7:0] INV_EXP = 8'd254;

    logic [127:0] key_q, rk_q, st_q, ct_q, rkNext, stNext;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;
    logic         busy_q, valid_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 in GF(2^8), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (INV_EXP[i]) r = gmul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expandKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
        logic [127:0] sb, sr, o;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
            else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ k;
    endfunction

    always_comb begin
        rkNext = expandKey(rk_q, rcon_q);
        stNext = aesRound(st_q, rkNext, round_q == 4'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            rk_q    <= '0;
            st_q    <= '0;
            ct_q    <= '0;
            rcon_q  <= 8'h01;
            round_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (Load_Key && !busy_q) key_q <= in_data;
            if (Load_Data && !busy_q) begin
                st_q    <= in_data ^ key_q;
                rk_q    <= key_q;
                rcon_q  <= 8'h01;
                round_q <= 4'd1;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                st_q    <= stNext;
                rk_q    <= rkNext;
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
                if (round_q == 4'd10) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    ct_q    <= stNext;
                end
            end
        end
    end

    assign Ready_new_input = !busy_q;
    assign CTValid         = valid_q;
    assign CipherText      = ct_q;

endmodule

// File: rtl/aes_blk_fifo.sv
// Single-clock block FIFO; pushes while full and pops while empty are ignored,
// the owner decides how to flag them.
module aes_blk_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= din_i;
    end

endmodule

// File: rtl/aes_stream_wrapper.sv
// Bus-mapped AES-128 engine: staged plaintext queues into a PT FIFO, a feeder
// streams it through AES_Top under CT-FIFO credits, results queue for the CPU.
module aes_stream_wrapper
    import aes_wrap_pkg::*;
#(
    parameter int PT_DEPTH = 4,
    parameter int CT_DEPTH = 4
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iChipSelect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [3:0]  iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oIrq
);

    localparam int CNT_W = $clog2(((PT_DEPTH > CT_DEPTH) ? PT_DEPTH : CT_DEPTH) + 1);

    logic [3:0][31:0] staging_q;
    logic [127:0]     stagingBlk, keyHold_q, ptHead, ctHead, aesIn, aesCt;
    logic [CNT_W-1:0] ptCount, ctCount, inflight_q, inflight_d;
    logic             ptFull, ptEmpty, ctFull, ctEmpty, ptPush, ctPush, ctPop;
    logic             wrEn, rdEn, keyAccept, ptOvfSet, ctUdfSet, keyErrSet;
    logic             aesLoadKey, aesLoadData, aesReady, aesCtValid;
    logic             keyLoaded_q, gap_q, busy, creditOk, oIrq_q;
    logic [2:0]       sticky_q, sticky_d, irqEn_q, irqSrc;
    logic [31:0]      rdData, status, oData_q;
    feedState_e       state_q, state_d;

    assign stagingBlk = {staging_q[0], staging_q[1], staging_q[2], staging_q[3]};
    assign wrEn       = !iChipSelect_n && !iWrite_n;
    assign rdEn       = !iChipSelect_n && !iRead_n;
    assign busy       = (state_q != IDLE) || (inflight_q != '0);
    assign keyAccept  = wrEn && (iAddress == ADDR_KEY) && (state_q == IDLE) && ptEmpty
                        && (inflight_q == '0);
    assign keyErrSet  = wrEn && (iAddress == ADDR_KEY) && !keyAccept;
    assign ptPush     = wrEn && (iAddress == ADDR_PUSH) && !ptFull;
    assign ptOvfSet   = wrEn && (iAddress == ADDR_PUSH) && ptFull;
    assign ctPop      = wrEn && (iAddress == ADDR_POP) && !ctEmpty;
    assign ctUdfSet   = wrEn && (iAddress == ADDR_POP) && ctEmpty;
    assign ctPush     = aesCtValid && !ctFull;
    assign creditOk   = ({1'b0, ctCount} + {1'b0, inflight_q}) < (CNT_W+1)'(CT_DEPTH);

    aes_blk_fifo #(.WIDTH(128), .DEPTH(PT_DEPTH), .CNT_W(CNT_W)) uPtFifo (
        .clk(iClk), .rst(iReset), .push_i(ptPush), .pop_i(aesLoadData), .din_i(stagingBlk),
        .head_o(ptHead), .count_o(ptCount), .full_o(ptFull), .empty_o(ptEmpty)
    );

    aes_blk_fifo #(.WIDTH(128), .DEPTH(CT_DEPTH), .CNT_W(CNT_W)) uCtFifo (
        .clk(iClk), .rst(iReset), .push_i(ctPush), .pop_i(ctPop), .din_i(aesCt),
        .head_o(ctHead), .count_o(ctCount), .full_o(ctFull), .empty_o(ctEmpty)
    );

    AES_Top uAes (
        .clk(iClk), .rst(iReset), .Load_Key(aesLoadKey), .Load_Data(aesLoadData),
        .in_data(aesIn), .Ready_new_input(aesReady), .CTValid(aesCtValid), .CipherText(aesCt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (keyAccept) state_d = LOADKEY;
                else if (keyLoaded_q && !ptEmpty) state_d = FEED;
            end
            LOADKEY: if (aesLoadKey) state_d = IDLE;
            FEED:    if (ptEmpty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // gap_q keeps one idle cycle after every load so Ready_new_input can drop.
    always_comb begin
        aesLoadKey  = 1'b0;
        aesLoadData = 1'b0;
        aesIn       = keyHold_q;
        case (state_q)
            LOADKEY: aesLoadKey = aesReady && !gap_q;
            FEED: begin
                aesIn       = ptHead;
                aesLoadData = aesReady && !gap_q && !ptEmpty && creditOk;
            end
            default: ;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (aesLoadData && !aesCtValid) inflight_d = inflight_q + CNT_W'(1);
        else if (!aesLoadData && aesCtValid) inflight_d = inflight_q - CNT_W'(1);
        sticky_d = sticky_q;
        if (wrEn && (iAddress == ADDR_CLR)) sticky_d = sticky_q & ~iData[2:0];
        sticky_d = sticky_d | {keyErrSet, ctUdfSet, ptOvfSet};
        irqSrc = {|sticky_q, ptEmpty && !busy, !ctEmpty};
    end

    always_comb begin
        status                            = '0;
        status[ST_PT_LSB +: 8]            = 8'(ptCount);
        status[ST_CT_LSB +: 8]            = 8'(ctCount);
        status[ST_INF_LSB +: 8]           = 8'(inflight_q);
        status[ST_STICKY_LSB +: 3]        = sticky_q;
        status[ST_KEYLD]                  = keyLoaded_q;
        status[ST_READY]                  = aesReady;
        status[ST_BUSY]                   = busy;
        rdData = '0;
        case (iAddress)
            ADDR_STAGE0, ADDR_STAGE1, ADDR_STAGE2, ADDR_STAGE3: rdData = staging_q[iAddress[1:0]];
            ADDR_CT0:    rdData = ctEmpty ? 32'h0 : ctHead[127:96];
            ADDR_CT1:    rdData = ctEmpty ? 32'h0 : ctHead[95:64];
            ADDR_CT2:    rdData = ctEmpty ? 32'h0 : ctHead[63:32];
            ADDR_CT3:    rdData = ctEmpty ? 32'h0 : ctHead[31:0];
            ADDR_STATUS: rdData = status;
            ADDR_IRQEN:  rdData = {29'h0, irqEn_q};
            default:     rdData = '0;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= IDLE;
            staging_q   <= '0;
            keyHold_q   <= '0;
            inflight_q  <= '0;
            keyLoaded_q <= 1'b0;
            gap_q       <= 1'b0;
            sticky_q    <= '0;
            irqEn_q     <= '0;
            oData_q     <= '0;
            oIrq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            sticky_q   <= sticky_d;
            gap_q      <= aesLoadKey || aesLoadData;
            oIrq_q     <= |(irqEn_q & irqSrc);
            if (wrEn && (iAddress <= ADDR_STAGE3)) staging_q[iAddress[1:0]] <= iData;
            if (keyAccept) keyHold_q <= stagingBlk;
            if (aesLoadKey) keyLoaded_q <= 1'b1;
            if (wrEn && (iAddress == ADDR_IRQEN)) irqEn_q <= iData[2:0];
            if (rdEn) oData_q <= rdData;
        end
    end

    assign oData = oData_q;
    assign oIrq  = oIrq_q;

endmodule

// File: tb/tb_aes_stream_wrapper.sv
// Directed bench for aes_stream_wrapper: known-answer AES vectors flow through
// a ciphertext scoreboard, plus overflow, underflow, credit, key-error and reset cases.
module tb_aes_stream_wrapper;
    import aes_wrap_pkg::*;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic        iClk = 1'b0;
    logic        iReset, iChipSelect_n, iWrite_n, iRead_n, oIrq;
    logic [3:0]  iAddress;
    logic [31:0] iData, oData, rd;
    int          checks = 0, errors = 0, creditViol = 0, ctOvfSeen = 0;
    logic [127:0] expQ[$];

    always #5 iClk = ~iClk;

    aes_stream_wrapper dut (
        .iClk(iClk), .iReset(iReset), .iChipSelect_n(iChipSelect_n), .iWrite_n(iWrite_n),
        .iRead_n(iRead_n), .iAddress(iAddress), .iData(iData), .oData(oData), .oIrq(oIrq)
    );

    // Credit and CT-overflow invariants watched on every cycle.
    always @(negedge iClk) begin
        if (!iReset) begin
            if ((int'(dut.ctCount) + int'(dut.inflight_q)) > 4) creditViol++;
            if (dut.aesCtValid && dut.ctFull) ctOvfSeen++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
        @(negedge iClk);
        iChipSelect_n = 1'b1; iWrite_n = 1'b1;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
        @(negedge iClk);
        d = oData;
        iChipSelect_n = 1'b1; iRead_n = 1'b1;
    endtask

    task automatic writeBlock(input logic [127:0] b);
        for (int i = 0; i < 4; i++) applyStimulus(4'(i), b[127-32*i -: 32]);
    endtask

    task automatic waitStatus(input string tag, input logic [31:0] mask, input logic [31:0] want,
                              input int budget);
        logic [31:0] st;
        int n;
        n = 0;
        readReg(ADDR_STATUS, st);
        while (((st & mask) !== want) && (n < budget)) begin
            readReg(ADDR_STATUS, st);
            n++;
        end
        checkOutput(tag, st & mask, want);
    endtask

    task automatic loadKey(input string tag, input logic [127:0] k);
        writeBlock(k);
        applyStimulus(ADDR_KEY, 32'h0);
        waitStatus(tag, 32'h4, 32'h4, 50);
    endtask

    task automatic popAndCheck(input string tag);
        logic [31:0]  st, w;
        logic [127:0] exp;
        int n;
        n = 0;
        readReg(ADDR_STATUS, st);
        while ((st[23:16] == 8'd0) && (n < 200)) begin
            readReg(ADDR_STATUS, st);
            n++;
        end
        checkOutput({tag, "_avail"}, {31'h0, st[23:16] != 8'd0}, 32'd1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
        for (int i = 0; i < 4; i++) begin
            readReg(ADDR_CT0 + 4'(i), w);
            checkOutput($sformatf("%s_w%0d", tag, i), w, exp[127-32*i -: 32]);
        end
        applyStimulus(ADDR_POP, 32'h0);
    endtask

    initial begin
        iReset = 1'b1; iChipSelect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1;
        iAddress = '0; iData = '0;
        repeat (3) @(negedge iClk);
        checkOutput("rst_oData", oData, 32'h0);
        checkOutput("rst_oIrq", {31'h0, oIrq}, 32'h0);
        iReset = 1'b0;
        readReg(ADDR_STATUS, rd);
        checkOutput("rst_status", rd, 32'h0000_0002);
        readReg(ADDR_IRQEN, rd);
        checkOutput("rst_irqen", rd, 32'h0);

        $display("[TB] PT overflow without key");
        writeBlock(P1);
        readReg(ADDR_STAGE2, rd);
        checkOutput("staging_rd", rd, 32'h8899aabb);
        repeat (5) applyStimulus(ADDR_PUSH, 32'h0);
        readReg(ADDR_STATUS, rd);
        checkOutput("ovf_status", rd, 32'h0400_0012);
        applyStimulus(ADDR_CLR, 32'h1);
        readReg(ADDR_STATUS, rd);
        checkOutput("ovf_cleared", rd, 32'h0400_0002);
        @(negedge iClk); iReset = 1'b1;
        repeat (2) @(negedge iClk); iReset = 1'b0;
        readReg(ADDR_STATUS, rd);
        checkOutput("rst2_status", rd, 32'h0000_0002);

        $display("[TB] single FIPS-197 block");
        loadKey("keyA_loaded", K1);
        writeBlock(P1);
        applyStimulus(ADDR_PUSH, 32'h0);
        expQ.push_back(C1);
        waitStatus("ct_count1", 32'h00FF_0000, 32'h0001_0000, 100);
        popAndCheck("fips1");
        waitStatus("idleA", 32'hFFFF_FFFF, 32'h0000_0006, 30);

        $display("[TB] credit backpressure with 6 blocks");
        for (int b = 0; b < 6; b++) begin
            int n;
            n = 0;
            readReg(ADDR_STATUS, rd);
            while ((rd[31:24] >= 8'd4) && (n < 200)) begin
                readReg(ADDR_STATUS, rd);
                n++;
            end
            applyStimulus(ADDR_PUSH, 32'h0);
            expQ.push_back(C1);
        end
        waitStatus("credit_full", 32'hFFFF_FFFF, 32'h0204_0007, 300);
        repeat (40) @(negedge iClk);
        readReg(ADDR_STATUS, rd);
        checkOutput("credit_hold", rd, 32'h0204_0007);
        for (int b = 0; b < 6; b++) popAndCheck($sformatf("credit%0d", b));
        waitStatus("idleC", 32'hFFFF_FFFF, 32'h0000_0006, 30);

        $display("[TB] key write while busy");
        applyStimulus(ADDR_PUSH, 32'h0);
        expQ.push_back(C1);
        applyStimulus(ADDR_PUSH, 32'h0);
        expQ.push_back(C1);
        applyStimulus(ADDR_KEY, 32'h0);
        readReg(ADDR_STATUS, rd);
        checkOutput("key_err", rd & 32'h70, 32'h40);
        popAndCheck("oldkey0");
        popAndCheck("oldkey1");
        applyStimulus(ADDR_CLR, 32'h7);
        waitStatus("idleD", 32'hFFFF_FFFF, 32'h0000_0006, 30);
        loadKey("keyB_loaded", K2);
        writeBlock(P2);
        applyStimulus(ADDR_PUSH, 32'h0);
        expQ.push_back(C2);
        popAndCheck("fips2");
        waitStatus("idleE", 32'hFFFF_FFFF, 32'h0000_0006, 30);

        $display("[TB] CT underflow and interrupt");
        applyStimulus(ADDR_IRQEN, 32'h4);
        readReg(ADDR_IRQEN, rd);
        checkOutput("irqen_rd", rd, 32'h4);
        checkOutput("irq_before", {31'h0, oIrq}, 32'h0);
        applyStimulus(ADDR_POP, 32'h0);
        checkOutput("irq_cycle1", {31'h0, oIrq}, 32'h0);
        @(negedge iClk);
        checkOutput("irq_cycle2", {31'h0, oIrq}, 32'h1);
        readReg(ADDR_CT0, rd);
        checkOutput("ct0_empty", rd, 32'h0);
        readReg(ADDR_CT3, rd);
        checkOutput("ct3_empty", rd, 32'h0);
        readReg(ADDR_STATUS, rd);
        checkOutput("ct_udf", rd & 32'h70, 32'h20);

        $display("[TB] reset mid-operation");
        repeat (3) applyStimulus(ADDR_PUSH, 32'h0);
        @(posedge iClk);
        #2 iReset = 1'b1;
        #1;
        checkOutput("midrst_oData", oData, 32'h0);
        checkOutput("midrst_oIrq", {31'h0, oIrq}, 32'h0);
        @(negedge iClk);
        iReset = 1'b0;
        readReg(ADDR_STATUS, rd);
        checkOutput("midrst_status", rd, 32'h0000_0002);
        readReg(ADDR_IRQEN, rd);
        checkOutput("midrst_irqen", rd, 32'h0);
        repeat (40) @(negedge iClk);
        readReg(ADDR_STATUS, rd);
        checkOutput("midrst_noct", rd, 32'h0000_0002);

        checkOutput("credit_invariant", creditViol, 32'h0);
        checkOutput("ct_never_full_push", ctOvfSeen, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
